water_arbiter: RTL and testbench
================================

WATER_ARBITER -- requirements
Module: water_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 15, maximum grant length in clock cycles; legal range 1-15.
REQ-002 Parameter DEAD_TIME, default 2, valve-off settle cycles between grants; legal range 0-7.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 req  input  4  per-machine request for the shared water inlet; bit i is machine i; level, held until served.
REQ-006 done  input  4  per-machine release; bit i high while granted ends machine i's grant.
REQ-007 abort  input  4  per-machine abort, e.g. door open; bit i high masks req[i] and ends machine i's grant.
REQ-008 gnt  output  4  one-hot grant; all zero when no grant.
REQ-009 gnt_id  output  2  index of the granted machine; holds the last granted index when gnt is zero.
REQ-010 valve_on  output  1  inlet valve drive; high only in GRANT.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 timeout_pulse  output  1  one-cycle pulse when a grant is ended by MAX_HOLD.
REQ-013 timeout_id  output  2  machine index captured with timeout_pulse; holds until the next timeout.

Function
REQ-014 The state machine SHALL have the states IDLE, GRANT and SETTLE.
REQ-015 A requester i is eligible when req[i]=1 and abort[i]=0.
REQ-016 IDLE: if any requester is eligible at a clock edge, the block SHALL select a winner round-robin, searching from last_id+1 upward and wrapping from 3 to 0, and enter GRANT.
REQ-017 Grant latency: an eligible req sampled at edge k in IDLE SHALL give gnt and valve_on high after edge k, which is 1 cycle of latency.
REQ-018 On entering GRANT, last_id SHALL update to the winner; the hold counter (4-bit) SHALL load 1.
REQ-019 GRANT: gnt[gnt_id]=1 and valve_on=1; the hold counter SHALL increment by 1 per cycle.
REQ-020 GRANT SHALL end when any of these is sampled for the granted machine: done=1, req=0, abort=1, or hold counter equal to MAX_HOLD.
REQ-021 When the grant ends on MAX_HOLD alone, timeout_pulse SHALL be high for exactly the first cycle after GRANT, with timeout_id set to the granted machine.
REQ-022 Simultaneous done, req drop or abort with the MAX_HOLD expiry: release wins and no timeout_pulse is raised.
REQ-023 On ending GRANT, gnt and valve_on SHALL drop on the next edge and the block SHALL enter SETTLE for DEAD_TIME cycles, then go to IDLE.
REQ-024 With DEAD_TIME=0, the block SHALL go from GRANT directly to IDLE.
REQ-025 A new grant SHALL NOT start in the same cycle a grant ends; the minimum gap with valve_on low is max(DEAD_TIME,0)+1 cycles.
REQ-026 done, abort and req changes on non-granted machines SHALL NOT affect the current grant.
REQ-027 A timed-out machine that still requests SHALL rejoin round-robin normally and receive no priority.
REQ-028 At most one gnt bit SHALL be high in any cycle, and valve_on SHALL equal |gnt.

Reset
REQ-029 reset_n=0 SHALL force the following immediately, asynchronously: state IDLE, gnt=0, valve_on=0, busy=0, timeout_pulse=0, timeout_id=0, gnt_id=0, last_id=3, hold counter=0.
REQ-030 Reset asserted mid-GRANT SHALL drop valve_on without a SETTLE phase or timeout pulse.
REQ-031 After reset release, the first grant SHALL go to machine 0 if it is eligible.

Verification
REQ-032 Single requester: req=0001, done pulsed after 5 cycles of grant -> gnt=0001 one cycle after req, valve_on high for 5 cycles, then 2 cycles of SETTLE, busy=0, timeout_pulse never high.
REQ-033 Round-robin: req=1111 held, each grant released by done after 3 cycles -> grant order 0,1,2,3,0 with 3-cycle valve-off gaps (DEAD_TIME=2).
REQ-034 Timeout: req=0100 held, done never asserted -> grant ends after 15 cycles of valve_on, timeout_pulse one cycle, timeout_id=2, re-grant to machine 2 after SETTLE.
REQ-035 Abort: machine 1 granted, abort=0010 after 4 cycles while req=1010 -> gnt drops next edge, next grant goes to machine 3, and machine 1 is not granted while abort[1]=1.
REQ-036 Collision: done and MAX_HOLD expiry in the same cycle -> no timeout_pulse; DEAD_TIME=0 build -> the next eligible machine is granted one cycle after release.
REQ-037 Reset: reset_n pulled low mid-grant asynchronously between clock edges -> gnt and valve_on go to 0 before the next edge; after release with req=1001 -> machine 0 granted first.

Source files
------------

// File: rtl/water_arbiter.sv
// Round-robin arbiter giving one of four machines the shared water inlet valve.
// Latency: grant and valve_on rise one cycle after an eligible request is sampled in IDLE.
// Backpressure: req is a level held until served; a grant ends on done, req drop, abort or MAX_HOLD, then DEAD_TIME settle cycles.
module water_arbiter #(
  parameter int unsigned MAX_HOLD  = 15,
  parameter int unsigned DEAD_TIME = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic [3:0] done,
  input  logic [3:0] abort,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       valve_on,
  output logic       busy,
  output logic       timeout_pulse,
  output logic [1:0] timeout_id
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_SETTLE = 2'd2
  } state_e;

  // A zero dead time skips SETTLE entirely; the IDLE cycle alone provides the valve-off gap.
  localparam logic NO_SETTLE = (DEAD_TIME == 0);

  state_e      state_q, state_d;
  logic [1:0]  gnt_id_q, gnt_id_d;
  logic [1:0]  last_id_q, last_id_d;
  logic [3:0]  hold_q, hold_d;
  logic [2:0]  settle_q, settle_d;
  logic        tpulse_q, tpulse_d;
  logic [1:0]  tid_q, tid_d;

  logic [3:0]  eligible;
  logic        win_vld;
  logic [1:0]  win_id;
  logic [1:0]  cand;
  logic        release_hit;
  logic        hold_expired;

  // Aborted machines are masked out of arbitration.
  assign eligible = req & ~abort;

  // Release conditions and hold expiry look only at the machine currently granted.
  assign release_hit  = done[gnt_id_q] | ~req[gnt_id_q] | abort[gnt_id_q];
  assign hold_expired = (hold_q == 4'(MAX_HOLD));

  // Round-robin search starting just after the last winner, wrapping 3 -> 0.
  always_comb begin
    win_vld = 1'b0;
    win_id  = last_id_q;
    cand    = last_id_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_id_q + 2'(k);
      if (!win_vld && eligible[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  // Next-state logic: grant selection, hold counting, timeout capture and settle countdown.
  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    last_id_d = last_id_q;
    hold_d    = hold_q;
    settle_d  = settle_q;
    tpulse_d  = 1'b0;
    tid_d     = tid_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d   = S_GRANT;
          gnt_id_d  = win_id;
          last_id_d = win_id;
          hold_d    = 4'd1;
        end
      end
      S_GRANT: begin
        if (release_hit || hold_expired) begin
          // An explicit release on the expiry cycle takes precedence: no timeout is reported.
          if (!release_hit) begin
            tpulse_d = 1'b1;
            tid_d    = gnt_id_q;
          end
          if (NO_SETTLE) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_SETTLE;
            settle_d = 3'(DEAD_TIME);
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      S_SETTLE: begin
        if (settle_q <= 3'd1) begin
          state_d = S_IDLE;
        end else begin
          settle_d = settle_q - 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset drops the valve immediately with no settle or timeout report.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      gnt_id_q  <= 2'd0;
      last_id_q <= 2'd3;
      hold_q    <= 4'd0;
      settle_q  <= 3'd0;
      tpulse_q  <= 1'b0;
      tid_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      last_id_q <= last_id_d;
      hold_q    <= hold_d;
      settle_q  <= settle_d;
      tpulse_q  <= tpulse_d;
      tid_q     <= tid_d;
    end
  end

  // One-hot grant decoded from the held index while in GRANT.
  always_comb begin
    gnt = 4'b0000;
    if (state_q == S_GRANT) begin
      gnt[gnt_id_q] = 1'b1;
    end
  end

  assign gnt_id        = gnt_id_q;
  assign valve_on      = (state_q == S_GRANT);
  assign busy          = (state_q != S_IDLE);
  assign timeout_pulse = tpulse_q;
  assign timeout_id    = tid_q;

endmodule

// File: tb/tb_water_arbiter.sv
// Self-checking bench for water_arbiter: default build plus a short-hold, zero-dead-time build.
// Latency: each stimulus cycle is compared against a cycle-level reference model at the falling edge.
// Backpressure: not applicable; inputs are driven freely each cycle.
module tb_water_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req, done, abort;

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] gnt_id_a, gnt_id_b, tid_a, tid_b;
  logic       valve_a, valve_b, busy_a, busy_b, tp_a, tp_b;

  water_arbiter #(.MAX_HOLD(15), .DEAD_TIME(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done), .abort(abort),
    .gnt(gnt_a), .gnt_id(gnt_id_a), .valve_on(valve_a), .busy(busy_a),
    .timeout_pulse(tp_a), .timeout_id(tid_a)
  );

  water_arbiter #(.MAX_HOLD(3), .DEAD_TIME(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done), .abort(abort),
    .gnt(gnt_b), .gnt_id(gnt_id_b), .valve_on(valve_b), .busy(busy_b),
    .timeout_pulse(tp_b), .timeout_id(tid_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int gap, n_cyc, vcount;
  int order [5] = '{0, 1, 2, 3, 0};
  logic [3:0] rv, dv, av;

  // Reference model: who owns the inlet, for how long, and how many quiet cycles remain.
  typedef struct {
    int max_hold;
    int dead;
    int owner;
    int held;
    int cool;
    int last;
    int gid;
    bit tp;
    int tid;
  } model_t;

  model_t ma, mb;

  typedef struct {
    logic [3:0] r, d, a, g;
    logic       v, b, tp;
  } vec_t;

  vec_t tbl[$];

  function automatic model_t m_init(int mh, int dt);
    model_t m;
    m.max_hold = mh; m.dead = dt; m.owner = -1; m.held = 0; m.cool = 0;
    m.last = 3; m.gid = 0; m.tp = 0; m.tid = 0;
    return m;
  endfunction

  function automatic model_t m_step(model_t m, logic [3:0] r, logic [3:0] d, logic [3:0] a);
    model_t nm;
    bit rel;
    bit found;
    int c;
    nm = m;
    nm.tp = 0;
    found = 0;
    if (m.owner >= 0) begin
      rel = d[m.owner] || !r[m.owner] || a[m.owner];
      if (rel || m.held == m.max_hold) begin
        if (!rel) begin
          nm.tp = 1;
          nm.tid = m.owner;
        end
        nm.owner = -1;
        nm.cool = m.dead;
      end else begin
        nm.held = m.held + 1;
      end
    end else if (m.cool > 0) begin
      nm.cool = m.cool - 1;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        c = (m.last + k) % 4;
        if (!found && r[c] && !a[c]) begin
          found = 1;
          nm.owner = c; nm.last = c; nm.gid = c; nm.held = 1;
        end
      end
    end
    return nm;
  endfunction

  function automatic logic [3:0] m_gnt(model_t m);
    return (m.owner >= 0) ? (4'b0001 << m.owner) : 4'b0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a_gnt",    32'(gnt_a),    32'(m_gnt(ma)));
    chk("a_gnt_id", 32'(gnt_id_a), ma.gid);
    chk("a_valve",  32'(valve_a),  32'(ma.owner >= 0));
    chk("a_busy",   32'(busy_a),   32'(ma.owner >= 0 || ma.cool > 0));
    chk("a_tp",     32'(tp_a),     32'(ma.tp));
    chk("a_tid",    32'(tid_a),    ma.tid);
    chk("a_onehot", 32'($onehot0(gnt_a)), 32'd1);
    chk("b_gnt",    32'(gnt_b),    32'(m_gnt(mb)));
    chk("b_gnt_id", 32'(gnt_id_b), mb.gid);
    chk("b_valve",  32'(valve_b),  32'(mb.owner >= 0));
    chk("b_busy",   32'(busy_b),   32'(mb.owner >= 0 || mb.cool > 0));
    chk("b_tp",     32'(tp_b),     32'(mb.tp));
    chk("b_tid",    32'(tid_b),    mb.tid);
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, compare at the next falling edge.
  task automatic cycle(input logic [3:0] r, input logic [3:0] d, input logic [3:0] a);
    req = r; done = d; abort = a;
    @(posedge clk);
    ma = m_step(ma, r, d, a);
    mb = m_step(mb, r, d, a);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = 4'h0; done = 4'h0; abort = 4'h0;
    @(posedge clk);
    @(negedge clk);
    ma = m_init(15, 2);
    mb = m_init(3, 0);
    check_all();
    reset_n = 1'b1;
  endtask

  task automatic addv(input logic [3:0] r, input logic [3:0] d, input logic [3:0] a,
                      input logic [3:0] g, input logic v, input logic b);
    vec_t t;
    t.r = r; t.d = d; t.a = a; t.g = g; t.v = v; t.b = b; t.tp = 1'b0;
    tbl.push_back(t);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1; req = 4'h0; done = 4'h0; abort = 4'h0;
    #1;
    reset_n = 1'b0;
    ma = m_init(15, 2);
    mb = m_init(3, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt",    32'(gnt_a),    32'h0);
    chk("rst_gnt_id", 32'(gnt_id_a), 32'h0);
    chk("rst_valve",  32'(valve_a),  32'h0);
    chk("rst_busy",   32'(busy_a),   32'h0);
    chk("rst_tp",     32'(tp_a),     32'h0);
    chk("rst_tid",    32'(tid_a),    32'h0);
    check_all();
    reset_n = 1'b1;

    // Single requester, done after 5 grant cycles; then abort and masking of machine 1.
    addv(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 1);
    addv(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 1);
    addv(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 1);
    addv(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 1);
    addv(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 1);
    addv(4'b0001, 4'b0001, 4'b0000, 4'b0000, 0, 1);
    addv(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1);
    addv(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    addv(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    addv(4'b1010, 4'b0000, 4'b0000, 4'b0010, 1, 1);
    addv(4'b1010, 4'b0000, 4'b0000, 4'b0010, 1, 1);
    addv(4'b1010, 4'b0000, 4'b0000, 4'b0010, 1, 1);
    addv(4'b1010, 4'b0000, 4'b0000, 4'b0010, 1, 1);
    addv(4'b1010, 4'b0000, 4'b0010, 4'b0000, 0, 1);
    addv(4'b1010, 4'b0000, 4'b0010, 4'b0000, 0, 1);
    addv(4'b1010, 4'b0000, 4'b0010, 4'b0000, 0, 0);
    addv(4'b1010, 4'b0000, 4'b0010, 4'b1000, 1, 1);
    addv(4'b1010, 4'b1000, 4'b0010, 4'b0000, 0, 1);
    addv(4'b0010, 4'b0000, 4'b0010, 4'b0000, 0, 1);
    addv(4'b0010, 4'b0000, 4'b0010, 4'b0000, 0, 0);
    addv(4'b0010, 4'b0000, 4'b0010, 4'b0000, 0, 0);
    addv(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 1);
    addv(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1);
    addv(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1);
    addv(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r, tbl[i].d, tbl[i].a);
      chk($sformatf("tbl%0d_gnt", i),   32'(gnt_a),   32'(tbl[i].g));
      chk($sformatf("tbl%0d_valve", i), 32'(valve_a), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_busy", i),  32'(busy_a),  32'(tbl[i].b));
      chk($sformatf("tbl%0d_tp", i),    32'(tp_a),    32'(tbl[i].tp));
    end

    // Round-robin with all four requesting, each grant released after 3 cycles.
    do_reset();
    gap = 1;
    for (int g = 0; g < 5; g++) begin
      n_cyc = 0;
      cycle(4'hF, 4'h0, 4'h0);
      while (valve_a !== 1'b1 && n_cyc < 10) begin
        gap++;
        cycle(4'hF, 4'h0, 4'h0);
        n_cyc++;
      end
      if (g > 0) chk($sformatf("rr%0d_gap", g), gap, 3);
      chk($sformatf("rr%0d_order", g), 32'(gnt_a), 32'(4'b0001 << order[g]));
      cycle(4'hF, 4'h0, 4'h0);
      cycle(4'hF, 4'h0, 4'h0);
      cycle(4'hF, 4'hF, 4'h0);
      chk($sformatf("rr%0d_release", g), 32'(valve_a), 32'h0);
      gap = 1;
    end
    for (int i = 0; i < 3; i++) cycle(4'h0, 4'h0, 4'h0);

    // Timeout: machine 2 holds until MAX_HOLD, then rejoins after settle.
    vcount = 0; n_cyc = 0;
    cycle(4'b0100, 4'h0, 4'h0);
    while (valve_a === 1'b1 && n_cyc < 40) begin
      vcount++;
      cycle(4'b0100, 4'h0, 4'h0);
      n_cyc++;
    end
    chk("to_valve_cycles", vcount, 15);
    chk("to_pulse", 32'(tp_a), 32'h1);
    chk("to_id", 32'(tid_a), 32'h2);
    cycle(4'b0100, 4'h0, 4'h0);
    chk("to_pulse_once", 32'(tp_a), 32'h0);
    gap = 2; n_cyc = 0;
    cycle(4'b0100, 4'h0, 4'h0);
    while (valve_a !== 1'b1 && n_cyc < 10) begin
      gap++;
      cycle(4'b0100, 4'h0, 4'h0);
      n_cyc++;
    end
    chk("to_regrant_gap", gap, 3);
    chk("to_regrant", 32'(gnt_a), 32'h4);
    chk("to_id_held", 32'(tid_a), 32'h2);
    for (int i = 0; i < 4; i++) cycle(4'h0, 4'h0, 4'h0);

    // Collision on the short build: done on the expiry cycle, then immediate regrant.
    do_reset();
    cycle(4'b0011, 4'h0, 4'h0);
    cycle(4'b0011, 4'h0, 4'h0);
    cycle(4'b0011, 4'h0, 4'h0);
    cycle(4'b0011, 4'b0001, 4'h0);
    chk("colb_tp", 32'(tp_b), 32'h0);
    chk("colb_drop", 32'(gnt_b), 32'h0);
    cycle(4'b0010, 4'h0, 4'h0);
    chk("colb_next", 32'(gnt_b), 32'h2);
    chk("colb_tp2", 32'(tp_b), 32'h0);
    for (int i = 0; i < 4; i++) cycle(4'h0, 4'h0, 4'h0);

    // Collision on the default build at hold count 15.
    cycle(4'b0001, 4'h0, 4'h0);
    for (int i = 0; i < 14; i++) cycle(4'b0001, 4'h0, 4'h0);
    chk("cola_held", 32'(valve_a), 32'h1);
    cycle(4'b0001, 4'b0001, 4'h0);
    chk("cola_tp", 32'(tp_a), 32'h0);
    chk("cola_drop", 32'(valve_a), 32'h0);
    cycle(4'h0, 4'h0, 4'h0);
    chk("cola_tp2", 32'(tp_a), 32'h0);
    for (int i = 0; i < 3; i++) cycle(4'h0, 4'h0, 4'h0);

    // Asynchronous reset between edges during a grant.
    cycle(4'b1001, 4'h0, 4'h0);
    cycle(4'b1001, 4'h0, 4'h0);
    chk("ar_pre_valve", 32'(valve_a), 32'h1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt_a), 32'h0);
    chk("ar_valve", 32'(valve_a), 32'h0);
    chk("ar_busy", 32'(busy_a), 32'h0);
    chk("ar_gnt_b", 32'(gnt_b), 32'h0);
    chk("ar_valve_b", 32'(valve_b), 32'h0);
    ma = m_init(15, 2);
    mb = m_init(3, 0);
    @(negedge clk);
    check_all();
    reset_n = 1'b1;
    cycle(4'b1001, 4'h0, 4'h0);
    chk("ar_first", 32'(gnt_a), 32'h1);
    chk("ar_no_tp", 32'(tp_a), 32'h0);
    for (int i = 0; i < 4; i++) cycle(4'h0, 4'h0, 4'h0);

    // Randomised traffic against the model.
    rv = 4'b0101;
    for (int i = 0; i < 500; i++) begin
      dv = 4'h0; av = 4'h0;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) rv[b] = ~rv[b];
        dv[b] = ($urandom_range(0, 9) == 0);
        av[b] = ($urandom_range(0, 19) == 0);
      end
      cycle(rv, dv, av);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
